// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding and the dispatch/CDB bundle types.
package alu_pkg;

  localparam int ALU_XLEN  = 32;
  localparam int ALU_TAG_W = 4;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  typedef struct packed {
    logic                 valid;
    logic [3:0]           op;
    logic [ALU_TAG_W-1:0] tag;
    logic [ALU_XLEN-1:0]  v1;
    logic [ALU_XLEN-1:0]  v2;
  } alu_req_t;

  typedef struct packed {
    logic                 valid;
    logic [ALU_TAG_W-1:0] tag;
    logic [ALU_XLEN-1:0]  value;
  } cdb_t;

endpackage

// File: rtl/alu_core.sv
// Pure combinational integer ALU: op/v1/v2 -> result, modulo 2^XLEN.
module alu_core
  import alu_pkg::*;
#(
  parameter int XLEN = ALU_XLEN
) (
  input  logic [3:0]      op_i,
  input  logic [XLEN-1:0] v1_i,
  input  logic [XLEN-1:0] v2_i,
  output logic [XLEN-1:0] result_o
);

  localparam int SHW = $clog2(XLEN);

  logic        [SHW-1:0]  shamt;
  logic signed [XLEN-1:0] s1;
  logic signed [XLEN-1:0] s2;

  assign shamt = v2_i[SHW-1:0];
  assign s1    = v1_i;
  assign s2    = v2_i;

  // Opcode decode; unknown opcodes produce zero
  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_ADD:  result_o = v1_i + v2_i;
      ALU_SUB:  result_o = v1_i - v2_i;
      ALU_AND:  result_o = v1_i & v2_i;
      ALU_OR:   result_o = v1_i | v2_i;
      ALU_XOR:  result_o = v1_i ^ v2_i;
      ALU_SLL:  result_o = v1_i << shamt;
      ALU_SRL:  result_o = v1_i >> shamt;
      ALU_SRA:  result_o = s1 >>> shamt;
      ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, (s1 < s2)};
      ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, (v1_i < v2_i)};
      default:  result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution stage: compute, park result in a small FIFO, hand it to the
// CDB with req/gnt, and return a credit to the reservation station.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN  = ALU_XLEN,
  parameter int TAG_W = ALU_TAG_W,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       valid_i,
  input  logic [3:0]                 op_i,
  input  logic [TAG_W-1:0]           tag_i,
  input  logic [XLEN-1:0]            v1_i,
  input  logic [XLEN-1:0]            v2_i,
  output logic                       alu_en_o,
  output logic                       cdb_req_o,
  input  logic                       cdb_gnt_i,
  output logic [TAG_W-1:0]           cdb_tag_o,
  output logic [XLEN-1:0]            cdb_value_o,
  output logic [$clog2(DEPTH):0]     occ_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [XLEN-1:0]  result;
  logic [TAG_W-1:0] tag_mem [DEPTH];
  logic [XLEN-1:0]  val_mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             full;
  logic             push;
  logic             pop;

  alu_core #(.XLEN(XLEN)) u_core (
    .op_i     (op_i),
    .v1_i     (v1_i),
    .v2_i     (v2_i),
    .result_o (result)
  );

  assign full = (count == DEPTH_C);
  // A flush cycle must never look like a CDB transfer downstream.
  assign cdb_req_o = (count != '0) && !flush_i;
  assign pop       = cdb_req_o && cdb_gnt_i;
  // Overflowing pushes are dropped; a same-cycle pop frees the slot.
  assign push      = valid_i && !flush_i && (!full || pop);

  // Head fields come straight from the buffer, zeroed while idle.
  assign cdb_tag_o   = cdb_req_o ? tag_mem[rd_ptr] : '0;
  assign cdb_value_o = cdb_req_o ? val_mem[rd_ptr] : '0;
  assign occ_o       = count;

  // Pop is not credited, so gnt has no combinational path to alu_en.
  assign alu_en_o = ({1'b0, count} + {{CW{1'b0}}, valid_i}) < {1'b0, DEPTH_C};

  // Buffer storage: data only, no reset needed since count gates visibility
  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr] <= tag_i;
      val_mem[wr_ptr] <= result;
    end
  end

  // FIFO pointers and occupancy; flush dominates push and pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(valid_i && !flush_i && full && !pop));

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized and directed bench for alu_exec_unit with a queue-based model.
module tb_alu_exec_unit;
  import alu_pkg::*;

  localparam int XLEN  = 32;
  localparam int TAG_W = 4;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush_i;
  logic             valid_i;
  logic [3:0]       op_i;
  logic [TAG_W-1:0] tag_i;
  logic [XLEN-1:0]  v1_i;
  logic [XLEN-1:0]  v2_i;
  logic             alu_en_o;
  logic             cdb_req_o;
  logic             cdb_gnt_i;
  logic [TAG_W-1:0] cdb_tag_o;
  logic [XLEN-1:0]  cdb_value_o;
  logic [1:0]       occ_o;

  alu_exec_unit #(.XLEN(XLEN), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush_i),
    .valid_i     (valid_i),
    .op_i        (op_i),
    .tag_i       (tag_i),
    .v1_i        (v1_i),
    .v2_i        (v2_i),
    .alu_en_o    (alu_en_o),
    .cdb_req_o   (cdb_req_o),
    .cdb_gnt_i   (cdb_gnt_i),
    .cdb_tag_o   (cdb_tag_o),
    .cdb_value_o (cdb_value_o),
    .occ_o       (occ_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  value;
  } ent_t;

  ent_t model_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU written from the arithmetic definitions.
  function automatic logic [XLEN-1:0] ref_alu(input logic [3:0] op,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    int unsigned sh;
    logic [XLEN-1:0] ones;
    sh   = b % XLEN;
    ones = '1;
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_SLL:  return a << sh;
      ALU_SRL:  return a >> sh;
      ALU_SRA:  return (a >> sh) | (a[XLEN-1] ? ~(ones >> sh) : '0);
      ALU_SLT:  return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      default:  return '0;
    endcase
  endfunction

  // One clock: drive inputs, check outputs at negedge, advance model at posedge.
  task automatic step(input logic v, input logic [3:0] op, input logic [TAG_W-1:0] tg,
                      input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                      input logic g, input logic f);
    logic exp_req;
    ent_t e;
    valid_i   = v;
    op_i      = op;
    tag_i     = tg;
    v1_i      = a;
    v2_i      = b;
    cdb_gnt_i = g;
    flush_i   = f;
    @(negedge clk);
    exp_req = (model_q.size() != 0) && !f;
    check("occ", occ_o, model_q.size());
    check("cdb_req", cdb_req_o, exp_req);
    check("alu_en", alu_en_o, (model_q.size() + int'(v)) < DEPTH);
    if (exp_req) begin
      check("cdb_tag", cdb_tag_o, model_q[0].tag);
      check("cdb_value", cdb_value_o, model_q[0].value);
    end
    @(posedge clk);
    if (f) begin
      model_q.delete();
    end else begin
      if (exp_req && g) void'(model_q.pop_front());
      if (v) begin
        e.tag   = tg;
        e.value = ref_alu(op, a, b);
        model_q.push_back(e);
      end
    end
    #1;
  endtask

  task automatic idle(input logic g);
    step(1'b0, ALU_ADD, '0, '0, '0, g, 1'b0);
  endtask

  task automatic dir_op(input logic [3:0] op, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tg,
                        input logic [XLEN-1:0] exp);
    step(1'b1, op, tg, a, b, 1'b0, 1'b0);
    check("dir_value", cdb_value_o, exp);
    check("dir_tag", cdb_tag_o, tg);
    idle(1'b1);
  endtask

  function automatic logic [XLEN-1:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [XLEN-1:0] held;
    logic            g;
    logic            f;
    logic            v;
    rst_n = 1'b0; flush_i = 1'b0; valid_i = 1'b0; op_i = '0; tag_i = '0;
    v1_i = '0; v2_i = '0; cdb_gnt_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_occ", occ_o, 0);
    check("rst_req", cdb_req_o, 0);
    check("rst_alu_en", alu_en_o, 1);
    check("rst_tag", cdb_tag_o, 0);
    check("rst_value", cdb_value_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ADD with grant held: visible next cycle, then retired
    step(1'b1, ALU_ADD, 4'd3, 32'd7, 32'd5, 1'b1, 1'b0);
    check("add_req", cdb_req_o, 1);
    check("add_tag", cdb_tag_o, 3);
    check("add_value", cdb_value_o, 12);
    idle(1'b1);
    check("add_occ_after", occ_o, 0);

    // Edge-case arithmetic
    dir_op(ALU_SUB,  32'h0,         32'h1, 4'd1, 32'hFFFF_FFFF);
    dir_op(ALU_SRA,  32'h8000_0000, 32'd36, 4'd2, 32'hF800_0000);
    dir_op(ALU_SLT,  32'hFFFF_FFFF, 32'h1, 4'd4, 32'd1);
    dir_op(ALU_SLTU, 32'hFFFF_FFFF, 32'h1, 4'd5, 32'd0);
    dir_op(4'hE,     32'h1234,      32'h1, 4'd6, 32'd0);

    // Back-to-back dispatch with no grant: credit drops, head stable, in-order retire
    step(1'b1, ALU_OR,  4'd8, 32'hA0, 32'h0B, 1'b0, 1'b0);
    step(1'b1, ALU_XOR, 4'd9, 32'hFF, 32'h0F, 1'b0, 1'b0);
    held = cdb_value_o;
    idle(1'b0);
    check("stall_value", cdb_value_o, held);
    check("stall_tag", cdb_tag_o, 8);
    idle(1'b1);
    check("order_tag2", cdb_tag_o, 9);
    idle(1'b1);

    // Full buffer with push+pop each cycle across pointer wrap
    step(1'b1, ALU_ADD, 4'd1, 32'd1, 32'd0, 1'b0, 1'b0);
    step(1'b1, ALU_ADD, 4'd2, 32'd2, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, ALU_ADD, 4'(10 + i), 32'(100 + i), 32'd0, 1'b1, 1'b0);
      check("full_occ", occ_o, 2);
    end
    check("wrap_head_tag", cdb_tag_o, 11);
    idle(1'b1);
    idle(1'b1);

    // Flush with valid and grant: no transfer, buffer empty afterwards
    step(1'b1, ALU_AND, 4'd7, 32'hF0, 32'h3C, 1'b0, 1'b0);
    step(1'b1, ALU_AND, 4'd6, 32'hF0, 32'h3C, 1'b1, 1'b1);
    check("flush_occ", occ_o, 0);
    check("flush_req", cdb_req_o, 0);
    idle(1'b1);

    // Random traffic, staying inside the credit protocol
    for (int i = 0; i < 400; i++) begin
      g = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 24) == 0);
      v = ($urandom_range(0, 2) != 0) &&
          ((model_q.size() < DEPTH) || (model_q.size() != 0 && g && !f));
      step(v, 4'($urandom_range(0, 11)), 4'($urandom), rand_operand(), rand_operand(), g, f);
    end

    // Asynchronous reset mid-stream with two results buffered
    idle(1'b0);
    step(1'b0, ALU_ADD, '0, '0, '0, 1'b0, 1'b1);
    step(1'b1, ALU_ADD, 4'd4, 32'd1, 32'd1, 1'b0, 1'b0);
    step(1'b1, ALU_ADD, 4'd5, 32'd2, 32'd2, 1'b0, 1'b0);
    check("pre_rst_occ", occ_o, 2);
    valid_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_occ", occ_o, 0);
    check("arst_req", cdb_req_o, 0);
    check("arst_alu_en", alu_en_o, 1);
    check("arst_value", cdb_value_o, 0);
    model_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
